// File: rtl/logic_eqn_sweep.sv
// Truth-table evaluator: single-vector lookup or exhaustive sweep of
// N_OUT sum-of-minterms functions, checking each vector against expected tables.
module logic_eqn_sweep #(
  parameter int unsigned N_IN  = 3,
  parameter int unsigned N_OUT = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         start_i,
  input  logic                         mode_i,
  input  logic                         abort_i,
  input  logic [N_IN-1:0]              vec_i,
  input  logic [N_OUT*(2**N_IN)-1:0]   mint_mask_i,
  input  logic [N_OUT*(2**N_IN)-1:0]   exp_mask_i,
  output logic [N_OUT-1:0]             f_o,
  output logic                         f_valid_o,
  output logic [N_IN-1:0]              cur_vec_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         pass_o,
  output logic [N_IN:0]                fail_cnt_o,
  output logic [N_IN-1:0]              first_fail_o
);

  localparam int unsigned NV = 2**N_IN;
  localparam int unsigned M  = N_OUT*NV;
  localparam int unsigned CW = N_IN+1;

  typedef enum logic [1:0] {S_IDLE, S_EVAL, S_SWEEP, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [M-1:0]      mint_q, mint_d;
  logic [M-1:0]      exp_q, exp_d;
  logic [N_IN-1:0]   vec_q, vec_d;
  logic [N_IN-1:0]   cnt_q, cnt_d;
  logic [N_OUT-1:0]  f_q, f_d;
  logic              f_valid_q, f_valid_d;
  logic [N_IN-1:0]   cur_vec_q, cur_vec_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [CW-1:0]     fail_cnt_q, fail_cnt_d;
  logic [N_IN-1:0]   first_fail_q, first_fail_d;

  logic [N_IN-1:0]   sel_vec_c;
  logic [N_OUT-1:0]  f_bit_c;
  logic [N_OUT-1:0]  mis_bit_c;

  // Vector being looked up this cycle: captured vector in EVAL, sweep counter otherwise
  assign sel_vec_c = (state_q == S_EVAL) ? vec_q : cnt_q;

  // Per-function truth-table slices and lookup at the selected vector
  for (genvar k = 0; k < N_OUT; k++) begin : g_fn
    logic [NV-1:0] mint_tt;
    logic [NV-1:0] exp_tt;
    assign mint_tt      = mint_q[k*NV +: NV];
    assign exp_tt       = exp_q[k*NV +: NV];
    assign f_bit_c[k]   = mint_tt[sel_vec_c];
    assign mis_bit_c[k] = mint_tt[sel_vec_c] ^ exp_tt[sel_vec_c];
  end

  // State and output registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= S_IDLE;
      mint_q       <= '0;
      exp_q        <= '0;
      vec_q        <= '0;
      cnt_q        <= '0;
      f_q          <= '0;
      f_valid_q    <= 1'b0;
      cur_vec_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_cnt_q   <= '0;
      first_fail_q <= '0;
    end else begin
      state_q      <= state_d;
      mint_q       <= mint_d;
      exp_q        <= exp_d;
      vec_q        <= vec_d;
      cnt_q        <= cnt_d;
      f_q          <= f_d;
      f_valid_q    <= f_valid_d;
      cur_vec_q    <= cur_vec_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      fail_cnt_q   <= fail_cnt_d;
      first_fail_q <= first_fail_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    mint_d       = mint_q;
    exp_d        = exp_q;
    vec_d        = vec_q;
    cnt_d        = cnt_q;
    f_d          = f_q;
    f_valid_d    = 1'b0;
    cur_vec_d    = cur_vec_q;
    done_d       = 1'b0;
    pass_d       = pass_q;
    fail_cnt_d   = fail_cnt_q;
    first_fail_d = first_fail_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          mint_d = mint_mask_i;
          exp_d  = exp_mask_i;
          vec_d  = vec_i;
          if (mode_i) begin
            state_d      = S_SWEEP;
            cnt_d        = '0;
            fail_cnt_d   = '0;
            first_fail_d = '0;
            pass_d       = 1'b0;
          end else begin
            state_d = S_EVAL;
          end
        end
      end
      S_EVAL: begin
        f_d       = f_bit_c;
        cur_vec_d = vec_q;
        f_valid_d = 1'b1;
        state_d   = S_IDLE;
      end
      S_SWEEP: begin
        // Abort pre-empts the vector currently addressed, including the last one
        if (abort_i) begin
          state_d = S_IDLE;
          pass_d  = 1'b0;
        end else begin
          f_d       = f_bit_c;
          cur_vec_d = cnt_q;
          f_valid_d = 1'b1;
          if (|mis_bit_c) begin
            fail_cnt_d = fail_cnt_q + CW'(1);
            if (fail_cnt_q == '0) first_fail_d = cnt_q;
          end
          if (cnt_q == '1) state_d = S_DONE;
          else             cnt_d   = cnt_q + N_IN'(1);
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        pass_d  = (fail_cnt_q == '0);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_EVAL) || (state_d == S_SWEEP);
  end

  assign f_o          = f_q;
  assign f_valid_o    = f_valid_q;
  assign cur_vec_o    = cur_vec_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign pass_o       = pass_q;
  assign fail_cnt_o   = fail_cnt_q;
  assign first_fail_o = first_fail_q;

endmodule

// File: tb/tb_logic_eqn_sweep.sv
// Directed bench for logic_eqn_sweep: vector table plus multi-cycle corner sequences.
module tb_logic_eqn_sweep;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance: N_IN=3, N_OUT=2
  logic        rst_n, start, mode, abort;
  logic [2:0]  vec;
  logic [15:0] mint, expm;
  logic [1:0]  f;
  logic        fv, busy, done, pass;
  logic [2:0]  cv, ffirst;
  logic [3:0]  fcnt;

  // Second instance: N_IN=3, N_OUT=1
  logic        s1_start, s1_mode, s1_abort;
  logic [2:0]  s1_vec;
  logic [7:0]  s1_mint, s1_exp;
  logic [0:0]  f1;
  logic        fv1, busy1, done1, pass1;
  logic [2:0]  cv1, ffirst1;
  logic [3:0]  fcnt1;

  logic_eqn_sweep #(.N_IN(3), .N_OUT(2)) u0 (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .mode_i(mode), .abort_i(abort),
    .vec_i(vec), .mint_mask_i(mint), .exp_mask_i(expm),
    .f_o(f), .f_valid_o(fv), .cur_vec_o(cv), .busy_o(busy), .done_o(done),
    .pass_o(pass), .fail_cnt_o(fcnt), .first_fail_o(ffirst)
  );

  logic_eqn_sweep #(.N_IN(3), .N_OUT(1)) u1 (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(s1_start), .mode_i(s1_mode), .abort_i(s1_abort),
    .vec_i(s1_vec), .mint_mask_i(s1_mint), .exp_mask_i(s1_exp),
    .f_o(f1), .f_valid_o(fv1), .cur_vec_o(cv1), .busy_o(busy1), .done_o(done1),
    .pass_o(pass1), .fail_cnt_o(fcnt1), .first_fail_o(ffirst1)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        mode;
    logic [2:0]  vec;
    logic [15:0] mint;
    logic [15:0] expm;
    int          ef;      // expected f_o (single mode)
    int          efail;   // expected fail count (sweep)
    int          efirst;  // expected first failing vector (sweep)
  } vec_t;

  vec_t tv[17];

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present a start for one edge, then scramble inputs to prove they were captured
  task automatic start_run(input logic m, input logic [2:0] v, input logic [15:0] mi,
                           input logic [15:0] ex);
    mode  = m;
    vec   = v;
    mint  = mi;
    expm  = ex;
    start = 1'b1;
    tick;
    start = 1'b0;
    mint  = ~mi;
    expm  = ~ex;
    vec   = ~v;
  endtask

  task automatic sweep_chk(input logic [15:0] mi, input logic [15:0] ex, input int efail,
                           input int efirst, input logic chkf, input logic [15:0] fseq);
    int nv, nd, dat, ord_err, f_err, fail_at, first_at;
    logic pass_at;
    nv = 0; nd = 0; dat = 0; ord_err = 0; f_err = 0; fail_at = -1; first_at = -1;
    pass_at = 1'b0;
    start_run(1'b1, 3'd0, mi, ex);
    chk("sweep_busy", int'(busy), 1);
    for (int c = 1; c <= 12; c++) begin
      tick;
      if (fv) begin
        if (nv < 8) begin
          if (cv !== 3'(nv)) ord_err++;
          if (chkf && (f !== fseq[2*nv +: 2])) f_err++;
        end
        nv++;
      end
      if (done) begin
        nd++;
        dat      = c;
        pass_at  = pass;
        fail_at  = int'(fcnt);
        first_at = int'(ffirst);
      end
    end
    chk("sweep_nvalid", nv, 8);
    chk("sweep_order", ord_err, 0);
    if (chkf) chk("sweep_fvals", f_err, 0);
    chk("sweep_ndone", nd, 1);
    chk("sweep_done_cycle", dat, 9);
    chk("sweep_fail_cnt", fail_at, efail);
    chk("sweep_first_fail", first_at, efirst);
    chk("sweep_pass", int'(pass_at), (efail == 0) ? 1 : 0);
    chk("sweep_pass_hold", int'(pass), (efail == 0) ? 1 : 0);
    chk("sweep_idle_busy", int'(busy), 0);
  endtask

  initial begin
    int nv, nd, dat, last_fail;

    tv[0]  = '{1'b1, 3'd0, 16'h74E4, 16'h74E4, 0, 0, 0};
    tv[1]  = '{1'b1, 3'd0, 16'h74E4, 16'h74E6, 0, 1, 1};
    tv[2]  = '{1'b1, 3'd0, 16'h00F0, 16'h0000, 0, 4, 4};
    tv[3]  = '{1'b1, 3'd0, 16'h8000, 16'h0000, 0, 1, 7};
    tv[4]  = '{1'b1, 3'd0, 16'h0100, 16'h0001, 0, 1, 0};
    tv[5]  = '{1'b1, 3'd0, 16'h1200, 16'h0012, 0, 2, 1};
    tv[6]  = '{1'b1, 3'd0, 16'h0000, 16'hFFFF, 0, 8, 0};
    tv[7]  = '{1'b0, 3'd2, 16'h74E4, 16'h0000, 3, 0, 0};
    tv[8]  = '{1'b0, 3'd4, 16'h74E4, 16'h0000, 2, 0, 0};
    tv[9]  = '{1'b0, 3'd7, 16'h74E4, 16'h0000, 1, 0, 0};
    tv[10] = '{1'b0, 3'd0, 16'h74E4, 16'h0000, 0, 0, 0};
    tv[11] = '{1'b0, 3'd3, 16'hFFFF, 16'h0000, 3, 0, 0};
    tv[12] = '{1'b0, 3'd6, 16'h0000, 16'h0000, 0, 0, 0};
    tv[13] = '{1'b0, 3'd0, 16'h8001, 16'h0000, 1, 0, 0};
    tv[14] = '{1'b0, 3'd7, 16'h8001, 16'h0000, 2, 0, 0};
    tv[15] = '{1'b0, 3'd7, 16'h0180, 16'h0000, 1, 0, 0};
    tv[16] = '{1'b0, 3'd0, 16'h0180, 16'h0000, 2, 0, 0};

    rst_n = 1'b1; start = 1'b0; mode = 1'b0; abort = 1'b0; vec = '0; mint = '0; expm = '0;
    s1_start = 1'b0; s1_mode = 1'b0; s1_abort = 1'b0; s1_vec = '0; s1_mint = '0; s1_exp = '0;
    last_fail = 0;

    // Power-up reset values
    #3 rst_n = 1'b0;
    #1;
    chk("rst_f", int'(f), 0);
    chk("rst_valid", int'(fv), 0);
    chk("rst_cur_vec", int'(cv), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_pass", int'(pass), 0);
    chk("rst_fail_cnt", int'(fcnt), 0);
    chk("rst_first_fail", int'(ffirst), 0);
    chk("rst1_outs", int'({f1, fv1, cv1, busy1, done1, pass1, fcnt1, ffirst1}), 0);
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick;

    // Table-driven vectors
    for (int i = 0; i < 17; i++) begin
      if (tv[i].mode) begin
        sweep_chk(tv[i].mint, tv[i].expm, tv[i].efail, tv[i].efirst, (i == 0), 16'h7E30);
        last_fail = tv[i].efail;
      end else begin
        start_run(1'b0, tv[i].vec, tv[i].mint, 16'h0000);
        chk("eval_busy", int'(busy), 1);
        tick;
        chk("eval_valid", int'(fv), 1);
        chk("eval_f", int'(f), tv[i].ef);
        chk("eval_cur_vec", int'(cv), int'(tv[i].vec));
        chk("eval_keeps_cnt", int'(fcnt), last_fail);
        tick;
        chk("eval_valid_drop", int'(fv), 0);
        chk("eval_f_hold", int'(f), tv[i].ef);
        chk("eval_no_done", int'(done), 0);
      end
    end

    // Single evaluation on the one-function instance
    s1_mode = 1'b0; s1_vec = 3'd5; s1_mint = 8'hA6; s1_exp = 8'h00; s1_start = 1'b1;
    tick;
    s1_start = 1'b0; s1_mint = 8'h00; s1_vec = 3'd0;
    tick;
    chk("n1_valid", int'(fv1), 1);
    chk("n1_f", int'(f1), 1);
    chk("n1_cur_vec", int'(cv1), 5);
    chk("n1_done", int'(done1), 0);
    tick;
    chk("n1_valid_drop", int'(fv1), 0);
    chk("n1_f_hold", int'(f1), 1);
    chk("n1_done2", int'(done1), 0);

    // abort_i in IDLE and EVAL has no effect
    abort = 1'b1;
    start_run(1'b0, 3'd5, 16'h74E4, 16'h0000);
    tick;
    abort = 1'b0;
    chk("abort_eval_valid", int'(fv), 1);
    chk("abort_eval_f", int'(f), 3);
    tick;

    // Abort at the 4th valid cycle of a fully failing sweep
    start_run(1'b1, 3'd0, 16'h74E4, 16'h8B1B);
    for (int c = 1; c <= 4; c++) tick;
    chk("abort4_pre_valid", int'(fv), 1);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("abort4_valid", int'(fv), 0);
    chk("abort4_busy", int'(busy), 0);
    chk("abort4_fail_cnt", int'(fcnt), 4);
    chk("abort4_first_fail", int'(ffirst), 0);
    chk("abort4_pass", int'(pass), 0);
    chk("abort4_cur_vec_hold", int'(cv), 3);
    nv = 0; nd = 0;
    for (int c = 0; c < 8; c++) begin
      tick;
      if (fv) nv++;
      if (done) nd++;
    end
    chk("abort4_no_valid", nv, 0);
    chk("abort4_no_done", nd, 0);
    chk("abort4_cnt_kept", int'(fcnt), 4);

    // Abort coinciding with the last vector
    start_run(1'b1, 3'd0, 16'h74E4, 16'h8B1B);
    for (int c = 1; c <= 7; c++) tick;
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("abort_last_valid", int'(fv), 0);
    chk("abort_last_fail_cnt", int'(fcnt), 7);
    nd = 0;
    for (int c = 0; c < 6; c++) begin
      tick;
      if (done) nd++;
    end
    chk("abort_last_no_done", nd, 0);
    chk("abort_last_pass", int'(pass), 0);

    // Asynchronous reset mid-sweep, then a clean rerun
    start_run(1'b1, 3'd0, 16'hFFFF, 16'h0000);
    for (int c = 1; c <= 3; c++) tick;
    chk("pre_rst_fail_cnt", int'(fcnt), 3);
    chk("pre_rst_f", int'(f), 3);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_f", int'(f), 0);
    chk("mid_rst_valid", int'(fv), 0);
    chk("mid_rst_cur_vec", int'(cv), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_fail_cnt", int'(fcnt), 0);
    chk("mid_rst_first", int'(ffirst), 0);
    chk("mid_rst_done_pass", int'({done, pass}), 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick;
    sweep_chk(16'h74E4, 16'h74E4, 0, 0, 1'b1, 16'h7E30);

    // start_i held high through a whole sweep and DONE
    mode = 1'b1; mint = 16'h74E4; expm = 16'h74E4; vec = '0; start = 1'b1;
    tick;
    nv = 0; nd = 0; dat = 0;
    for (int c = 1; c <= 10; c++) begin
      tick;
      if (fv) nv++;
      if (done) begin
        nd++;
        dat = c;
      end
    end
    chk("held_nvalid", nv, 8);
    chk("held_ndone", nd, 1);
    chk("held_done_cycle", dat, 9);
    tick;
    chk("held_rerun_valid", int'(fv), 1);
    chk("held_rerun_vec", int'(cv), 0);
    start = 1'b0;
    nd = 0;
    for (int c = 0; c < 12; c++) begin
      tick;
      if (done) nd++;
    end
    chk("held_rerun_done", nd, 1);
    chk("held_rerun_pass", int'(pass), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/logic_eqn_sweep.md
LOGIC_EQN_SWEEP -- requirements
Module: logic_eqn_sweep

Interface
REQ-001 Parameter N_IN, default 3, number of function inputs; legal range 2..6.
REQ-002 Parameter N_OUT, default 2, number of independent output functions; legal range 1..4.
REQ-003 Local width M = N_OUT*2^N_IN; bit k*2^N_IN+m of any mask = minterm m of function k.
REQ-004 clk_i  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n_i  input  1  reset, asynchronous, active-low.
REQ-006 start_i  input  1  start request; sampled only in IDLE.
REQ-007 mode_i  input  1  0 = single evaluation of vec_i, 1 = exhaustive sweep of all 2^N_IN vectors.
REQ-008 abort_i  input  1  abort an active sweep.
REQ-009 vec_i  input  N_IN  input vector for single mode; MSB = first variable.
REQ-010 mint_mask_i  input  M  minterm masks defining the functions (sum of minterms).
REQ-011 exp_mask_i  input  M  expected truth tables for sweep checking.
REQ-012 f_o  output  N_OUT  registered function outputs, bit k = function k.
REQ-013 f_valid_o  output  1  f_o/cur_vec_o valid this cycle.
REQ-014 cur_vec_o  output  N_IN  vector that produced the current f_o.
REQ-015 busy_o  output  1  high in EVAL and SWEEP.
REQ-016 done_o  output  1  one-cycle pulse at sweep completion.
REQ-017 pass_o  output  1  valid with done_o, held until next start: 1 when fail_cnt_o == 0.
REQ-018 fail_cnt_o  output  N_IN+1  number of swept vectors with any output mismatch.
REQ-019 first_fail_o  output  N_IN  lowest failing vector index; 0 when none.

Function
REQ-020 FSM states IDLE, EVAL, SWEEP, DONE; state encoding free.
REQ-021 IDLE & start_i & !mode_i -> EVAL; IDLE & start_i & mode_i -> SWEEP; start_i ignored outside IDLE.
REQ-022 On accepted start: mint_mask_i, exp_mask_i, vec_i captured into registers; later input changes have no effect until next start.
REQ-023 EVAL: f_o[k] = mask[k*2^N_IN + vec], cur_vec_o = vec, f_valid_o = 1 for exactly one cycle, 1 cycle after start; then IDLE; counters untouched.
REQ-024 SWEEP start clears fail_cnt_o, first_fail_o, pass_o; vector counter starts at 0.
REQ-025 SWEEP: one vector per cycle, ascending 0..2^N_IN-1; f_o/cur_vec_o/f_valid_o registered, first valid cycle 1 cycle after start; 2^N_IN consecutive valid cycles, no gaps.
REQ-026 Mismatch = any k where mint bit != exp bit for that vector; increments fail_cnt_o by 1 (no saturation needed; max 2^N_IN fits).
REQ-027 first_fail_o loads on first mismatch of a sweep only; later mismatches do not change it.
REQ-028 After last vector (2^N_IN-1), counter does not wrap; FSM -> DONE for one cycle: done_o = 1, pass_o = (fail_cnt == 0) including last vector's result; then IDLE.
REQ-029 start_i high during DONE is ignored; new run needs start_i in IDLE.
REQ-030 abort_i in SWEEP: next cycle IDLE, f_valid_o = 0, done_o not asserted, pass_o = 0, fail_cnt_o/first_fail_o keep partial values; abort_i ignored in other states.
REQ-031 abort_i and the last vector in the same cycle: abort wins; no done_o.
REQ-032 f_o holds last value when f_valid_o = 0.

Reset
REQ-033 rst_n_i low: immediately (asynchronously) state = IDLE, f_o = 0, f_valid_o = 0, cur_vec_o = 0, busy_o = 0, done_o = 0, pass_o = 0, fail_cnt_o = 0, first_fail_o = 0, captured masks = 0.
REQ-034 Reset mid-sweep discards the run; first start after release behaves as from power-up.

Verification
REQ-035 N_IN=3, N_OUT=2, mode 1, mint = exp = 16'h74E4 (F1 = m(2,5,6,7), F2 = m(2,4,5,6)) -> 8 valid cycles, f_o = 0,0,3,0,2,3,3,1 for vec 0..7, done_o at cycle 9, pass_o=1, fail_cnt_o=0.
REQ-036 Same, exp = 16'h74E6 -> fail_cnt_o=1, first_fail_o=1, pass_o=0.
REQ-037 N_OUT=1, mode 0, mint=8'hA6, vec_i=5 -> one cycle later f_valid_o=1, f_o=1, cur_vec_o=5, done_o stays 0.
REQ-038 Sweep with exp = ~mint, abort_i at 4th valid cycle -> IDLE next cycle, no done_o, fail_cnt_o=4, first_fail_o=0.
REQ-039 rst_n_i low mid-sweep (asynchronous, between edges) -> all outputs 0 at once; restart after release gives REQ-035 result.
REQ-040 start_i held high through a full sweep and DONE -> exactly one run, one done_o; a second run starts only on the next IDLE cycle.
